// File: rtl/seq_mult.sv
// Radix-2 shift-and-add multiplier: one partial product per clock, one operation in flight.
// Latency WIDTH+1 cycles from accept to out_valid_o; DONE holds the product until out_ready_i.
module seq_mult #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] p_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand, acc, p_q;
  logic [WIDTH-1:0]     mplier, a_mag, b_mag;
  logic [CW-1:0]        cnt;
  logic                 neg, neg_in, last, accept, step, finish;

  // Signed mode works on magnitudes; -2^(W-1) maps to 2^(W-1), which still fits unsigned W bits.
  always_comb begin
    a_mag  = a_i;
    b_mag  = b_i;
    neg_in = 1'b0;
    if (SIGNED != 0) begin
      if (a_i[WIDTH-1]) a_mag = -a_i;
      if (b_i[WIDTH-1]) b_mag = -b_i;
      neg_in = a_i[WIDTH-1] ^ b_i[WIDTH-1];
    end
  end

  assign last   = (cnt == CW'(WIDTH));
  assign accept = (state == IDLE) && in_valid_i;
  assign step   = (state == RUN) && !last;
  assign finish = (state == RUN) && last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_nxt = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      p_q    <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= '0;
      neg    <= neg_in;
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end else if (finish) begin
      // Sign fix happens on the DONE-entry edge; p_q then holds until the next completion.
      p_q <= neg ? -acc : acc;
    end
  end

  assign p_o = p_q;

endmodule
